rx_serial: RTL and testbench

Asynchronous serial receiver. It is the receive-side counterpart of the team's oversampled transmitter. It recovers 7-bit ASCII frames from `dado_serial` using 16× tick oversampling with mid-bit sampling, then presents the character with a held-valid/acknowledge handshake. It sits between the board's RX pin and the character consumer logic. It contains a tick generator, a shift register and bit counter (datapath), and a Moore control unit.

---
 rtl/rx_serial_pkg.sv | 53 +++++
 rtl/rx_serial_if.sv | 38 +++
 rtl/rx_serial_uc.sv | 63 ++++++
 rtl/rx_serial.sv | 148 ++++++++++++++
 tb/tb_rx_serial.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rx_serial_pkg.sv
// rx_serial_pkg: shared constants, state codes and payload types for the serial receiver.
// Optional feature macro: RX_SERIAL_PARITY_EN (7O1 frames when defined, 7N1 otherwise).
package rx_serial_pkg;

  localparam int unsigned DATA_W  = 7;
  localparam int unsigned STATE_W = 4;

`ifdef RX_SERIAL_PARITY_EN
  // Data bits + parity + stop, sampled after the start bit.
  localparam int unsigned FRAME_BITS = DATA_W + 2;
`else
  // Data bits + stop, sampled after the start bit.
  localparam int unsigned FRAME_BITS = DATA_W + 1;
`endif

  // State encodings double as the db_estado debug codes.
  localparam logic [STATE_W-1:0] ST_INICIAL    = 4'h0;
  localparam logic [STATE_W-1:0] ST_PREPARACAO = 4'h1;
  localparam logic [STATE_W-1:0] ST_CONFIRMA   = 4'h2;
  localparam logic [STATE_W-1:0] ST_ESPERA     = 4'h3;
  localparam logic [STATE_W-1:0] ST_RECEPCAO   = 4'h7;
  localparam logic [STATE_W-1:0] ST_ARMAZENA   = 4'hB;
  localparam logic [STATE_W-1:0] ST_FINAL_RX   = 4'hF;
  localparam logic [STATE_W-1:0] DB_ILEGAL     = 4'hE;

  // Moore control outputs of the control unit.
  typedef struct packed {
    logic zera;
    logic conta;
    logic desloca;
    logic carrega;
    logic pronto;
  } uc_ctrl_t;

  // Character delivered to the consumer together with its status flags.
  typedef struct packed {
    logic [DATA_W-1:0] dados;
    logic              erro_paridade;
    logic              erro_stop;
  } rx_result_t;

  // Map a state to its debug code; anything unknown reports as illegal.
  function automatic logic [STATE_W-1:0] db_code(input logic [STATE_W-1:0] st);
    logic [STATE_W-1:0] code;
    case (st)
      ST_INICIAL, ST_PREPARACAO, ST_CONFIRMA, ST_ESPERA,
      ST_RECEPCAO, ST_ARMAZENA, ST_FINAL_RX: code = st;
      default:                               code = DB_ILEGAL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rx_serial_if.sv
// rx_serial_if: serial line, consumer handshake and status bundle of the receiver.
interface rx_serial_if;
  import rx_serial_pkg::*;

  logic                dado_serial;
  logic                recebe_dado;
  logic [DATA_W-1:0]   dados_ascii;
  logic                tem_dado;
  logic                pronto;
  logic                erro_paridade;
  logic                erro_stop;
  logic [STATE_W-1:0]  db_estado;

  // Line driver / character consumer side.
  modport master (
    output dado_serial,
    output recebe_dado,
    input  dados_ascii,
    input  tem_dado,
    input  pronto,
    input  erro_paridade,
    input  erro_stop,
    input  db_estado
  );

  // Receiver side.
  modport slave (
    input  dado_serial,
    input  recebe_dado,
    output dados_ascii,
    output tem_dado,
    output pronto,
    output erro_paridade,
    output erro_stop,
    output db_estado
  );

endinterface

// File: rtl/rx_serial_uc.sv
// rx_serial_uc: Moore control unit of the serial receiver.
// Outputs are registered from the next state so they line up with the state they belong to.
module rx_serial_uc
  import rx_serial_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               borda_i,      // falling edge seen on the synchronized line
  input  logic               tick_i,       // oversampling tick
  input  logic               meio_i,       // tick count sits at the mid-bit terminal value
  input  logic               linha_alta_i, // synchronized line level (false-start compare)
  input  logic               fim_bits_i,   // current bit is the last one of the frame
  output uc_ctrl_t           ctrl_o,
  output logic [STATE_W-1:0] db_estado_o
);

  logic [STATE_W-1:0] estado_q, estado_d;
  uc_ctrl_t           ctrl_q, ctrl_d;
  logic [STATE_W-1:0] db_q, db_d;
  logic               amostra;

  // Next-state and Moore output decode.
  always_comb begin
    estado_d = estado_q;
    ctrl_d   = '0;
    amostra  = tick_i && meio_i;

    case (estado_q)
      ST_INICIAL:    if (borda_i) estado_d = ST_PREPARACAO;
      ST_PREPARACAO: estado_d = ST_CONFIRMA;
      ST_CONFIRMA:   if (amostra) estado_d = linha_alta_i ? ST_INICIAL : ST_ESPERA;
      ST_ESPERA:     if (amostra) estado_d = ST_RECEPCAO;
      ST_RECEPCAO:   estado_d = fim_bits_i ? ST_ARMAZENA : ST_ESPERA;
      ST_ARMAZENA:   estado_d = ST_FINAL_RX;
      ST_FINAL_RX:   estado_d = ST_INICIAL;
      default:       estado_d = ST_INICIAL;
    endcase

    ctrl_d.zera    = (estado_d == ST_PREPARACAO);
    ctrl_d.conta   = (estado_d == ST_CONFIRMA) || (estado_d == ST_ESPERA);
    ctrl_d.desloca = (estado_d == ST_RECEPCAO);
    ctrl_d.carrega = (estado_d == ST_ARMAZENA);
    ctrl_d.pronto  = (estado_d == ST_FINAL_RX);
    db_d           = db_code(estado_d);
  end

  // State and registered Moore outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= ST_INICIAL;
      ctrl_q   <= '0;
      db_q     <= ST_INICIAL;
    end else begin
      estado_q <= estado_d;
      ctrl_q   <= ctrl_d;
      db_q     <= db_d;
    end
  end

  assign ctrl_o      = ctrl_q;
  assign db_estado_o = db_q;

endmodule

// File: rtl/rx_serial.sv
// rx_serial: oversampled asynchronous serial receiver for 7-bit ASCII frames.
// Optional feature macro: RX_SERIAL_PARITY_EN (odd parity bit checked when defined).
// CLOCKS_PER_TICK must be >= 2; OVERSAMPLE must be even and >= 4.
module rx_serial
  import rx_serial_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_TICK = 326,
  parameter int unsigned OVERSAMPLE      = 16
) (
  input  logic        clock,
  input  logic        reset,
  rx_serial_if.slave  rx
);

  localparam int unsigned TICK_W = $clog2(CLOCKS_PER_TICK);
  localparam int unsigned OS_W   = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(FRAME_BITS + 1);

  // Synchronizer and edge-detect flops; they reset to the idle line level.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q,   dly_d;

  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [OS_W-1:0]       ovs_cnt_q,  ovs_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q,    shift_d;
  rx_result_t            res_q,      res_d;
  logic                  tem_dado_q, tem_dado_d;

  logic     tick;
  logic     borda;
  logic     meio;
  logic     fim_bits;
  uc_ctrl_t ctrl;

  // Status flags derived from the packed shift register (bit 0 = first data bit).
  rx_result_t frame_res;

  // Decode of the datapath flags handed to the control unit.
  always_comb begin
    tick     = (tick_cnt_q == TICK_W'(CLOCKS_PER_TICK - 1));
    borda    = !sync2_q && dly_q;
    // The oversample counter free-runs modulo OVERSAMPLE from the start edge, so
    // every mid-bit sample point lands on the same counter value.
    meio     = (ovs_cnt_q == OS_W'(OVERSAMPLE / 2 - 1));
    fim_bits = (bit_cnt_q == BIT_W'(FRAME_BITS - 1));
  end

  // Frame interpretation of the assembled shift register.
  always_comb begin
    frame_res.dados     = shift_q[DATA_W-1:0];
    frame_res.erro_stop = ~shift_q[FRAME_BITS-1];
`ifdef RX_SERIAL_PARITY_EN
    frame_res.erro_paridade = ~(^shift_q[DATA_W:0]);
`else
    frame_res.erro_paridade = 1'b0;
`endif
  end

  // Next-state logic for synchronizer, counters, shift register and output registers.
  always_comb begin
    sync1_d    = rx.dado_serial;
    sync2_d    = sync1_q;
    dly_d      = sync2_q;
    tick_cnt_d = tick_cnt_q;
    ovs_cnt_d  = ovs_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    res_d      = res_q;
    tem_dado_d = tem_dado_q;

    if (ctrl.zera) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end

    if (ctrl.zera) begin
      ovs_cnt_d = '0;
    end else if (tick && ctrl.conta) begin
      if (ovs_cnt_q == OS_W'(OVERSAMPLE - 1)) ovs_cnt_d = '0;
      else                                     ovs_cnt_d = ovs_cnt_q + OS_W'(1);
    end

    if (ctrl.zera) begin
      bit_cnt_d = '0;
    end else if (ctrl.desloca) begin
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
    end

    // LSB-first line: new bits enter at the top and drift down.
    if (ctrl.desloca) shift_d = {sync2_q, shift_q[FRAME_BITS-1:1]};

    if (ctrl.carrega) res_d = frame_res;

    // Set covers both the store cycle and the pronto cycle so that an
    // acknowledge coinciding with pronto cannot drop the new character.
    if (rx.recebe_dado)             tem_dado_d = 1'b0;
    if (ctrl.carrega || ctrl.pronto) tem_dado_d = 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      dly_q      <= 1'b1;
      tick_cnt_q <= '0;
      ovs_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      res_q      <= '0;
      tem_dado_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      dly_q      <= dly_d;
      tick_cnt_q <= tick_cnt_d;
      ovs_cnt_q  <= ovs_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      res_q      <= res_d;
      tem_dado_q <= tem_dado_d;
    end
  end

  rx_serial_uc u_uc (
    .clock        (clock),
    .reset        (reset),
    .borda_i      (borda),
    .tick_i       (tick),
    .meio_i       (meio),
    .linha_alta_i (sync2_q),
    .fim_bits_i   (fim_bits),
    .ctrl_o       (ctrl),
    .db_estado_o  (rx.db_estado)
  );

  assign rx.dados_ascii   = res_q.dados;
  assign rx.erro_paridade = res_q.erro_paridade;
  assign rx.erro_stop     = res_q.erro_stop;
  assign rx.tem_dado      = tem_dado_q;
  assign rx.pronto        = ctrl.pronto;

endmodule

// File: tb/tb_rx_serial.sv
// tb_rx_serial: scoreboard bench for rx_serial with directed frames.
// Works in both builds; RX_SERIAL_PARITY_EN selects 7O1 framing in the stimulus.
module tb_rx_serial;

  localparam int unsigned CPT      = 2;
  localparam int unsigned OS       = 16;
  localparam int unsigned BIT_CLKS = CPT * OS;

  typedef struct packed {
    logic [6:0] d;
    logic       pe;
    logic       se;
  } exp_t;

  logic clock;
  logic reset;
  rx_serial_if bus ();

  rx_serial #(.CLOCKS_PER_TICK(CPT), .OVERSAMPLE(OS)) dut (
    .clock (clock),
    .reset (reset),
    .rx    (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   pronto_cnt = 0;
  exp_t exp_q[$];

  logic       log_en = 1'b0;
  logic [3:0] last_db;
  logic [3:0] db_log[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every pronto pulse consumes one expected character.
  always @(negedge clock) begin
    if (bus.pronto === 1'b1) begin
      exp_t e;
      pronto_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pronto: got pronto with empty queue at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("dados_ascii", 32'(bus.dados_ascii), 32'(e.d));
        check("erro_paridade", 32'(bus.erro_paridade), 32'(e.pe));
        check("erro_stop", 32'(bus.erro_stop), 32'(e.se));
        check("tem_dado_at_pronto", 32'(bus.tem_dado), 32'd1);
      end
    end
  end

  // Debug state change logger used by the glitch case.
  always @(negedge clock) begin
    if (log_en && bus.db_estado !== last_db) begin
      db_log.push_back(bus.db_estado);
      last_db = bus.db_estado;
    end
  end

  task automatic send_bit(input logic b);
    bus.dado_serial = b;
    repeat (BIT_CLKS) @(negedge clock);
  endtask

  // One full frame followed by an idle gap; bad_par flips the odd parity bit.
  task automatic send_frame(input logic [6:0] d, input logic bad_par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(d[i]);
`ifdef RX_SERIAL_PARITY_EN
    send_bit((~^d) ^ bad_par);
`else
    if (bad_par) $display("note: parity bit not transmitted in 7N1 build");
`endif
    send_bit(stp);
    bus.dado_serial = 1'b1;
    repeat (40) @(negedge clock);
  endtask

  task automatic ack();
    bus.recebe_dado = 1'b1;
    @(negedge clock);
    bus.recebe_dado = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int exp_seq[3];
    int n;
    exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 0;

    reset           = 1'b0;
    bus.dado_serial = 1'b1;
    bus.recebe_dado = 1'b0;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_dados", 32'(bus.dados_ascii), 32'h0);
    check("rst_tem_dado", 32'(bus.tem_dado), 32'h0);
    check("rst_pronto", 32'(bus.pronto), 32'h0);
    check("rst_erro_par", 32'(bus.erro_paridade), 32'h0);
    check("rst_erro_stop", 32'(bus.erro_stop), 32'h0);
    check("rst_db_estado", 32'(bus.db_estado), 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // 'A' with correct framing, held valid until acknowledged
    exp_q.push_back('{d: 7'h41, pe: 1'b0, se: 1'b0});
    send_frame(7'h41, 1'b0, 1'b1);
    check("A_pronto_count", 32'(pronto_cnt), 32'd1);
    repeat (20) @(negedge clock);
    check("A_tem_dado_held", 32'(bus.tem_dado), 32'd1);
    ack();
    check("A_tem_dado_cleared", 32'(bus.tem_dado), 32'd0);

    // Parity error (7O1 build); plain resend otherwise
`ifdef RX_SERIAL_PARITY_EN
    exp_q.push_back('{d: 7'h41, pe: 1'b1, se: 1'b0});
    send_frame(7'h41, 1'b1, 1'b1);
`else
    exp_q.push_back('{d: 7'h41, pe: 1'b0, se: 1'b0});
    send_frame(7'h41, 1'b0, 1'b1);
`endif
    ack();

    // Glitch: short low pulse must be rejected as a false start
    last_db = bus.db_estado;
    log_en  = 1'b1;
    n       = pronto_cnt;
    bus.dado_serial = 1'b0;
    repeat (8) @(negedge clock);
    bus.dado_serial = 1'b1;
    repeat (60) @(negedge clock);
    log_en = 1'b0;
    check("glitch_no_pronto", 32'(pronto_cnt), 32'(n));
    check("glitch_seq_len", 32'(db_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("glitch_seq", (i < db_log.size()) ? 32'(db_log[i]) : 32'hFF, 32'(exp_seq[i]));

    // Framing error, then overrun without acknowledge
    exp_q.push_back('{d: 7'h55, pe: 1'b0, se: 1'b1});
    send_frame(7'h55, 1'b0, 1'b0);
    exp_q.push_back('{d: 7'h2A, pe: 1'b0, se: 1'b0});
    send_frame(7'h2A, 1'b0, 1'b1);
    check("overrun_tem_dado", 32'(bus.tem_dado), 32'd1);
    check("overrun_dados", 32'(bus.dados_ascii), 32'h2A);
    check("overrun_erro_stop", 32'(bus.erro_stop), 32'd0);

    // Reset in the middle of the data bits of 0x30
    send_bit(1'b0);
    send_bit(1'b0);
    bus.dado_serial = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_dados", 32'(bus.dados_ascii), 32'h0);
    check("midrst_tem_dado", 32'(bus.tem_dado), 32'h0);
    check("midrst_pronto", 32'(bus.pronto), 32'h0);
    check("midrst_erro_stop", 32'(bus.erro_stop), 32'h0);
    check("midrst_db_estado", 32'(bus.db_estado), 32'h0);
    bus.dado_serial = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    exp_q.push_back('{d: 7'h30, pe: 1'b0, se: 1'b0});
    send_frame(7'h30, 1'b0, 1'b1);
    ack();
    check("post_rst_tem_dado", 32'(bus.tem_dado), 32'd0);

    // Acknowledge coincides with pronto: set must win
    exp_q.push_back('{d: 7'h7F, pe: 1'b0, se: 1'b0});
    fork
      send_frame(7'h7F, 1'b0, 1'b1);
      begin
        int w;
        w = 0;
        while (bus.pronto !== 1'b1 && w < 1000) begin
          @(negedge clock);
          w++;
        end
        check("ack_wait_pronto", 32'(bus.pronto), 32'd1);
        bus.recebe_dado = 1'b1;
        @(negedge clock);
        bus.recebe_dado = 1'b0;
        check("set_wins_tem_dado", 32'(bus.tem_dado), 32'd1);
      end
    join
    check("final_dados", 32'(bus.dados_ascii), 32'h7F);
    check("final_erro_par", 32'(bus.erro_paridade), 32'd0);
    ack();
    check("final_tem_dado_cleared", 32'(bus.tem_dado), 32'd0);

    check("pronto_total", 32'(pronto_cnt), 32'd6);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
